weight_dispatch: RTL and testbench

Parametrised weight loader that streams a block of weights out of the shared weight RAM and delivers them, one word per cycle, to N_UNITS neuron units. It generates the RAM addresses, tracks the fixed RAM read latency, and drives a shared weight bus with a per-unit write strobe. It also supports broadcast (one weight set to all units), an issue-hold input and a start/busy/done handshake. It sits between the weight RAM and the neuron array, replacing the fixed six-way registered unit demux.

---
 rtl/nn_pkg.sv | 17 +
 rtl/weight_dispatch_rd_tag_pipe.sv | 48 ++++
 rtl/weight_dispatch.sv | 153 +++++++++++++++
 tb/tb_weight_dispatch.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared definitions for the neuron-array datapath: weight dispatcher FSM
// states and an index-width helper that never returns zero.
package nn_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } dispatch_state_e;

   // Bits needed to index n items; a single item still gets one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/weight_dispatch_rd_tag_pipe.sv
// rd_tag_pipe: follows each RAM read through the fixed read latency so the
// returning word can be paired with its destination unit and index.
// Ports:
//   clk, rst                          clock, synchronous active-high clear
//   in_valid/in_unit/in_idx/in_bcast  tag of the read issued this cycle
//   out_*                             tag whose data is on ram_out this cycle
//   pending                           a tag is still inside the pipe, not yet at the output
module rd_tag_pipe #(
   parameter int unsigned LAT    = 1,
   parameter int unsigned UNIT_W = 3,
   parameter int unsigned IDX_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [UNIT_W-1:0] in_unit,
   input  logic [IDX_W-1:0]  in_idx,
   input  logic              in_bcast,
   output logic              out_valid,
   output logic [UNIT_W-1:0] out_unit,
   output logic [IDX_W-1:0]  out_idx,
   output logic              out_bcast,
   output logic              pending
);

   localparam int unsigned TAG_W = UNIT_W + IDX_W + 2;

   logic [TAG_W-1:0] pipe_q [LAT];

   // Shift register; stage LAT-1 lines up with valid ram_out.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(LAT); i++) pipe_q[i] <= '0;
      end else begin
         pipe_q[0] <= {in_valid, in_unit, in_idx, in_bcast};
         for (int i = 1; i < int'(LAT); i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

   assign {out_valid, out_unit, out_idx, out_bcast} = pipe_q[LAT-1];

   // Valid tags short of the output stage; the output stage is consumed this cycle.
   always_comb begin
      pending = 1'b0;
      for (int i = 0; i < int'(LAT) - 1; i++) pending = pending | pipe_q[i][TAG_W-1];
   end

endmodule

// File: rtl/weight_dispatch.sv
// weight_dispatch: streams a block of weights from the weight RAM onto a
// shared weight bus with per-unit write strobes (or all units in broadcast).
// Ports:
//   CLOCK, RESET          clock, synchronous active-high reset
//   start, base_addr,
//   broadcast             load request; address/mode latched when accepted in IDLE
//   hold                  suspends new RAM reads
//   ram_addr, ram_rd      RAM read request (ram_out valid RAM_LAT cycles later)
//   ram_out               RAM read data
//   weight_bus, write_vec,
//   weight_idx            registered weight delivery to the units
//   busy, done            status; done pulses for one cycle at completion
module weight_dispatch
   import nn_pkg::*;
#(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned N_UNITS = 6,
   parameter int unsigned WPU     = 16,
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned RAM_LAT = 1
) (
   input  logic                       CLOCK,
   input  logic                       RESET,
   input  logic                       start,
   input  logic [ADDR_W-1:0]          base_addr,
   input  logic                       broadcast,
   input  logic                       hold,
   output logic [ADDR_W-1:0]          ram_addr,
   output logic                       ram_rd,
   input  logic [DATA_W-1:0]          ram_out,
   output logic [DATA_W-1:0]          weight_bus,
   output logic [N_UNITS-1:0]         write_vec,
   output logic [idx_width(WPU)-1:0]  weight_idx,
   output logic                       busy,
   output logic                       done
);

   localparam int unsigned IDX_W  = idx_width(WPU);
   localparam int unsigned UNIT_W = idx_width(N_UNITS);

   dispatch_state_e   state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [ADDR_W-1:0] count_q, count_d;
   logic [UNIT_W-1:0] unit_q, unit_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              bcast_q, bcast_d;

   logic              last_rd_c;
   logic              tag_valid, tag_bcast, tag_pending;
   logic [UNIT_W-1:0] tag_unit;
   logic [IDX_W-1:0]  tag_idx;

   // Read request follows hold in the same cycle so a held cycle issues nothing.
   assign ram_rd   = (state_q == ST_ISSUE) && !hold;
   assign ram_addr = (state_q == ST_ISSUE) ? ADDR_W'(base_q + count_q) : '0;
   assign busy     = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
   assign done     = (state_q == ST_DONE);

   // Broadcast loads a single unit's worth of weights.
   assign last_rd_c = (idx_q == IDX_W'(WPU - 1)) &&
                      (bcast_q || (unit_q == UNIT_W'(N_UNITS - 1)));

   // State and load-context registers.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state_q <= ST_IDLE;
         base_q  <= '0;
         count_q <= '0;
         unit_q  <= '0;
         idx_q   <= '0;
         bcast_q <= 1'b0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         count_q <= count_d;
         unit_q  <= unit_d;
         idx_q   <= idx_d;
         bcast_q <= bcast_d;
      end
   end

   // Next-state and counter logic.
   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      count_d = count_q;
      unit_d  = unit_q;
      idx_d   = idx_q;
      bcast_d = bcast_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               base_d  = base_addr;
               bcast_d = broadcast;
               count_d = '0;
               unit_d  = '0;
               idx_d   = '0;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (!hold) begin
               count_d = ADDR_W'(count_q + 1'b1);
               if (idx_q == IDX_W'(WPU - 1)) begin
                  idx_d  = '0;
                  unit_d = UNIT_W'(unit_q + 1'b1);
               end else begin
                  idx_d  = IDX_W'(idx_q + 1'b1);
               end
               if (last_rd_c) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (!tag_pending) state_d = ST_DONE;
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   rd_tag_pipe #(
      .LAT    (RAM_LAT),
      .UNIT_W (UNIT_W),
      .IDX_W  (IDX_W)
   ) u_tag_pipe (
      .clk       (CLOCK),
      .rst       (RESET),
      .in_valid  (ram_rd),
      .in_unit   (unit_q),
      .in_idx    (idx_q),
      .in_bcast  (bcast_q),
      .out_valid (tag_valid),
      .out_unit  (tag_unit),
      .out_idx   (tag_idx),
      .out_bcast (tag_bcast),
      .pending   (tag_pending)
   );

   // Delivery register: bus is zero whenever no strobe is driven.
   always_ff @(posedge CLOCK) begin
      if (RESET || !tag_valid) begin
         weight_bus <= '0;
         write_vec  <= '0;
         weight_idx <= '0;
      end else begin
         weight_bus <= ram_out;
         weight_idx <= tag_idx;
         for (int k = 0; k < int'(N_UNITS); k++)
            write_vec[k] <= tag_bcast || (tag_unit == UNIT_W'(k));
      end
   end

endmodule

// File: tb/tb_weight_dispatch.sv
// Directed bench for weight_dispatch: RAM model returns data = address;
// expected strobes are queued when a load is started and popped per strobe.
module tb_weight_dispatch;
   import nn_pkg::*;

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned N_UNITS = 6;
   localparam int unsigned WPU     = 16;
   localparam int unsigned ADDR_W  = 8;
   localparam int unsigned RAM_LAT = 1;
   localparam int unsigned IDX_W   = idx_width(WPU);
   localparam int unsigned EXP_W   = N_UNITS + IDX_W + DATA_W;

   logic                CLOCK = 1'b0;
   logic                RESET;
   logic                start;
   logic [ADDR_W-1:0]   base_addr;
   logic                broadcast;
   logic                hold;
   logic [ADDR_W-1:0]   ram_addr;
   logic                ram_rd;
   logic [DATA_W-1:0]   ram_out;
   logic [DATA_W-1:0]   weight_bus;
   logic [N_UNITS-1:0]  write_vec;
   logic [IDX_W-1:0]    weight_idx;
   logic                busy;
   logic                done;

   logic [EXP_W-1:0]    sb_q [$];
   int                  errors = 0;
   int                  checks = 0;

   weight_dispatch #(
      .DATA_W (DATA_W), .N_UNITS (N_UNITS), .WPU (WPU),
      .ADDR_W (ADDR_W), .RAM_LAT (RAM_LAT)
   ) dut (
      .CLOCK      (CLOCK),
      .RESET      (RESET),
      .start      (start),
      .base_addr  (base_addr),
      .broadcast  (broadcast),
      .hold       (hold),
      .ram_addr   (ram_addr),
      .ram_rd     (ram_rd),
      .ram_out    (ram_out),
      .weight_bus (weight_bus),
      .write_vec  (write_vec),
      .weight_idx (weight_idx),
      .busy       (busy),
      .done       (done)
   );

   always #5 CLOCK = ~CLOCK;

   // Single-cycle-latency RAM whose contents equal the address.
   always @(posedge CLOCK) ram_out <= DATA_W'(ram_addr);

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] all_outs();
      return 64'({ram_addr, ram_rd, weight_bus, write_vec, weight_idx, busy, done});
   endfunction

   task automatic push_load(input logic [ADDR_W-1:0] base, input logic bc);
      logic [ADDR_W-1:0]  a;
      logic [N_UNITS-1:0] wv;
      int                 nu;
      nu = bc ? 1 : int'(N_UNITS);
      for (int k = 0; k < nu; k++) begin
         for (int i = 0; i < int'(WPU); i++) begin
            a  = ADDR_W'(int'(base) + k * int'(WPU) + i);
            wv = bc ? {N_UNITS{1'b1}} : N_UNITS'(N_UNITS'(1) << k);
            sb_q.push_back({wv, IDX_W'(i), DATA_W'(a)});
         end
      end
   endtask

   // One load from start to done; n counts cycles after the start cycle.
   task automatic run_load(input logic [ADDR_W-1:0] base, input logic bc,
                           input bit do_hold, input bit do_restart, input int exp_done);
      int               r, reads, strobes;
      bit               seen_done;
      logic [EXP_W-1:0] e;
      r = bc ? int'(WPU) : int'(N_UNITS * WPU);
      push_load(base, bc);
      base_addr = base;
      broadcast = bc;
      start     = 1'b1;
      @(posedge CLOCK); #1;
      start     = 1'b0;
      base_addr = 8'h33;
      broadcast = !bc;
      reads = 0; strobes = 0; seen_done = 0;
      for (int n = 1; n <= 300 && !seen_done; n++) begin
         if (n > 1) begin @(posedge CLOCK); #1; end
         hold  = do_hold && n >= 6 && n <= 8;
         start = do_restart && n == 20;
         #1;
         if (n == 1) begin
            check("first_rd", 64'(ram_rd), 64'(1));
            check("first_addr", 64'(ram_addr), 64'(base));
            check("busy_issue", 64'(busy), 64'(1));
         end
         if (hold) check("hold_rd", 64'(ram_rd), 64'(0));
         if (do_hold && n == 7) check("hold_inflight_vec", 64'(write_vec), 64'(1));
         if (ram_rd) reads++;
         if (write_vec != '0) begin
            strobes++;
            if (sb_q.size() == 0) begin
               check("extra_strobe", 64'(write_vec), 64'(0));
            end else begin
               e = sb_q.pop_front();
               check("strobe", 64'({write_vec, weight_idx, weight_bus}), 64'(e));
            end
         end else begin
            check("idle_bus", 64'({weight_idx, weight_bus}), 64'(0));
         end
         if (done) begin
            seen_done = 1;
            check("done_cycle", 64'(n), 64'(exp_done));
            check("busy_at_done", 64'(busy), 64'(0));
            check("read_count", 64'(reads), 64'(r));
            check("strobe_count", 64'(strobes), 64'(r));
            check("sb_empty", 64'(sb_q.size()), 64'(0));
         end
      end
      check("done_seen", 64'(seen_done), 64'(1));
      hold  = 1'b0;
      start = 1'b0;
      @(posedge CLOCK); #2;
      check("done_pulse_end", 64'(done), 64'(0));
      check("idle_after", 64'({busy, write_vec}), 64'(0));
      sb_q.delete();
   endtask

   initial begin
      RESET = 1'b1; start = 1'b0; base_addr = '0; broadcast = 1'b0; hold = 1'b0;
      repeat (3) @(posedge CLOCK);
      #2;
      check("reset_outs", all_outs(), 64'(0));
      RESET = 1'b0;
      @(posedge CLOCK); #2;
      check("idle_outs", all_outs(), 64'(0));

      // Normal load
      run_load(8'h10, 1'b0, 1'b0, 1'b0, 98);
      // Broadcast
      run_load(8'h40, 1'b1, 1'b0, 1'b0, 18);
      // Hold for three cycles after the fifth read
      run_load(8'h10, 1'b0, 1'b1, 1'b0, 101);
      // start pulsed while busy is ignored
      run_load(8'h10, 1'b0, 1'b0, 1'b1, 98);
      // Address wrap-around
      run_load(8'hF8, 1'b0, 1'b0, 1'b0, 98);

      // Reset in the middle of a load
      base_addr = 8'h20; broadcast = 1'b0; start = 1'b1;
      @(posedge CLOCK); #1;
      start = 1'b0;
      repeat (10) @(posedge CLOCK);
      #1;
      RESET = 1'b1;
      @(posedge CLOCK); #2;
      check("midreset_outs", all_outs(), 64'(0));
      @(posedge CLOCK); #1;
      RESET = 1'b0;
      #1;
      check("midreset_outs2", all_outs(), 64'(0));
      for (int n = 0; n < 10; n++) begin
         @(posedge CLOCK); #2;
         check("post_reset_quiet", 64'({ram_rd, write_vec, busy, done}), 64'(0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
